// File: rtl/legv8_pkg.sv
// Shared LEGv8 instruction constants: kind codes, 11-bit opcodes and format prefixes.
// The control decoder imports the same values, so encode and decode stay in lockstep.
package legv8_pkg;

    typedef enum logic [3:0] {
        KIND_LDUR = 4'd0,
        KIND_STUR = 4'd1,
        KIND_CBZ  = 4'd2,
        KIND_ADD  = 4'd3,
        KIND_SUB  = 4'd4,
        KIND_AND  = 4'd5,
        KIND_ORR  = 4'd6,
        KIND_LSL  = 4'd7,
        KIND_LSR  = 4'd8,
        KIND_B    = 4'd9
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FULL,
        ST_ERR
    } state_e;

    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;

    localparam logic [7:0] CB_PREFIX = 8'b10110100;
    localparam logic [5:0] B_PREFIX  = 6'b000101;

endpackage

// File: rtl/legv8_word_pack.sv
// Combinational packer: maps an instruction kind plus fields to a 32-bit LEGv8 word,
// flagging unknown kinds and immediates that do not fit their format field.
module legv8_word_pack
    import legv8_pkg::*;
(
    input  logic [3:0]  kind,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [5:0]  shamt,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        bad
);

    logic d_fits;
    logic cb_fits;

    // An immediate fits an N-bit signed field when every bit above it copies its sign bit.
    assign d_fits  = (&imm[25:8])  || !(|imm[25:8]);
    assign cb_fits = (&imm[25:18]) || !(|imm[25:18]);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        word = '0;
        bad  = 1'b0;
        case (kind)
            KIND_LDUR: begin
                word = {OP_LDUR, imm[8:0], 2'b00, rn, rd};
                bad  = !d_fits;
            end
            KIND_STUR: begin
                word = {OP_STUR, imm[8:0], 2'b00, rn, rd};
                bad  = !d_fits;
            end
            KIND_CBZ: begin
                word = {CB_PREFIX, imm[18:0], rd};
                bad  = !cb_fits;
            end
            KIND_ADD: word = {OP_ADD, rm, 6'd0, rn, rd};
            KIND_SUB: word = {OP_SUB, rm, 6'd0, rn, rd};
            KIND_AND: word = {OP_AND, rm, 6'd0, rn, rd};
            KIND_ORR: word = {OP_ORR, rm, 6'd0, rn, rd};
            KIND_LSL: word = {OP_LSL, 5'd0, shamt, rn, rd};
            KIND_LSR: word = {OP_LSR, 5'd0, shamt, rn, rd};
            KIND_B:   word = {B_PREFIX, imm};
            default:  bad  = 1'b1;
        endcase
    end

endmodule

// File: rtl/legv8_instr_encoder.sv
// Program loader: accepts symbolic instructions over valid/ready, encodes them and writes
// one word per cycle to instruction memory at sequential byte addresses from a base.
module legv8_instr_encoder
    import legv8_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [3:0]                 in_kind,
    input  logic [4:0]                 in_rd,
    input  logic [4:0]                 in_rn,
    input  logic [4:0]                 in_rm,
    input  logic [5:0]                 in_shamt,
    input  logic [25:0]                in_imm,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [31:0]                mem_wdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       err
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    state_e            state;
    state_e            state_nxt;
    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       word;
    logic              bad;
    logic              fire;

    legv8_word_pack u_pack (
        .kind  (in_kind),
        .rd    (in_rd),
        .rn    (in_rn),
        .rm    (in_rm),
        .shamt (in_shamt),
        .imm   (in_imm),
        .word  (word),
        .bad   (bad)
    );

    assign full     = (count == CNT_W'(DEPTH));
    assign in_ready = (state == ST_RUN) && !full;
    assign fire     = in_valid && in_ready;

    // start wins over a simultaneous handshake; that instruction is simply dropped.
    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_RUN;
        end else if (fire) begin
            if (bad)
                state_nxt = ST_ERR;
            else if (count == CNT_W'(DEPTH - 1))
                state_nxt = ST_FULL;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Pointer and count advance on the handshake edge, so count already includes the
    // word being presented on mem_wdata and in_ready drops before DEPTH is exceeded.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (!rst_n) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            err       <= 1'b0;
            wr_ptr    <= '0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                wr_ptr <= {base_addr[ADDR_W-1:2], 2'b00};
                count  <= '0;
                err    <= 1'b0;
            end else if (fire) begin
                if (bad) begin
                    err <= 1'b1;
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= wr_ptr;
                    mem_wdata <= word;
                    wr_ptr    <= wr_ptr + ADDR_W'(4);
                    count     <= count + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_legv8_instr_encoder.sv
// Directed bench: a table of single-instruction vectors with hand-encoded words, plus
// hand-written sequences for back-to-back writes, full, wrap, start priority and reset.
module tb_legv8_instr_encoder;
    import legv8_pkg::*;

    localparam int ADDR_W = 8;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] base_addr = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [3:0]        in_kind = '0;
    logic [4:0]        in_rd = '0;
    logic [4:0]        in_rn = '0;
    logic [4:0]        in_rm = '0;
    logic [5:0]        in_shamt = '0;
    logic [25:0]       in_imm = '0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [2:0]        count;
    logic              full;
    logic              err;

    int checks = 0;
    int errors = 0;

    legv8_instr_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_kind   (in_kind),
        .in_rd     (in_rd),
        .in_rn     (in_rn),
        .in_rm     (in_rm),
        .in_shamt  (in_shamt),
        .in_imm    (in_imm),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .count     (count),
        .full      (full),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  kind;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [5:0]  shamt;
        logic [25:0] imm;
        logic [31:0] exp_word;
        logic        exp_bad;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        start     = 1'b1;
        base_addr = base;
        step();
        start = 1'b0;
    endtask

    task automatic drive(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rn,
                         input logic [4:0] rm, input logic [5:0] sh, input logic [25:0] imm);
        in_valid = 1'b1;
        in_kind  = k;
        in_rd    = rd;
        in_rn    = rn;
        in_rm    = rm;
        in_shamt = sh;
        in_imm   = imm;
    endtask

    initial begin
        int nw;

        vecs[0]  = '{"add",       KIND_ADD,  5'd3,  5'd1,  5'd2,  6'd0,  26'd0,           32'h8B020023, 1'b0};
        vecs[1]  = '{"add_shamt", KIND_ADD,  5'd0,  5'd0,  5'd0,  6'd5,  26'd0,           32'h8B000000, 1'b0};
        vecs[2]  = '{"sub",       KIND_SUB,  5'd5,  5'd6,  5'd7,  6'd0,  26'd0,           32'hCB0700C5, 1'b0};
        vecs[3]  = '{"and",       KIND_AND,  5'd1,  5'd2,  5'd3,  6'd0,  26'd0,           32'h8A030041, 1'b0};
        vecs[4]  = '{"orr",       KIND_ORR,  5'd31, 5'd31, 5'd31, 6'd0,  26'd0,           32'hAA1F03FF, 1'b0};
        vecs[5]  = '{"lsl",       KIND_LSL,  5'd2,  5'd1,  5'd7,  6'd4,  26'd0,           32'hD3601022, 1'b0};
        vecs[6]  = '{"lsr",       KIND_LSR,  5'd4,  5'd8,  5'd9,  6'd63, 26'd0,           32'hD340FD04, 1'b0};
        vecs[7]  = '{"ldur",      KIND_LDUR, 5'd9,  5'd22, 5'd0,  6'd0,  26'd64,          32'hF84402C9, 1'b0};
        vecs[8]  = '{"ldur_max",  KIND_LDUR, 5'd0,  5'd0,  5'd0,  6'd0,  26'd255,         32'hF84FF000, 1'b0};
        vecs[9]  = '{"stur_min",  KIND_STUR, 5'd3,  5'd4,  5'd0,  6'd0,  26'(-256),       32'hF8100083, 1'b0};
        vecs[10] = '{"cbz_min",   KIND_CBZ,  5'd0,  5'd0,  5'd0,  6'd0,  26'(-262144),    32'hB4800000, 1'b0};
        vecs[11] = '{"b_neg",     KIND_B,    5'd0,  5'd0,  5'd0,  6'd0,  26'h3FFFFFF,     32'h17FFFFFF, 1'b0};
        vecs[12] = '{"ldur_256",  KIND_LDUR, 5'd0,  5'd0,  5'd0,  6'd0,  26'd256,         32'h0,        1'b1};
        vecs[13] = '{"stur_m257", KIND_STUR, 5'd0,  5'd0,  5'd0,  6'd0,  26'(-257),       32'h0,        1'b1};
        vecs[14] = '{"cbz_big",   KIND_CBZ,  5'd0,  5'd0,  5'd0,  6'd0,  26'd262144,      32'h0,        1'b1};
        vecs[15] = '{"kind_12",   4'd12,     5'd0,  5'd0,  5'd0,  6'd0,  26'd0,           32'h0,        1'b1};

        // Reset state
        step();
        step();
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst_n = 1'b1;
        step();
        check("idle_ready", 32'(in_ready), 32'd0);

        // Table: each vector is one fresh program of one instruction at base 0x40.
        foreach (vecs[i]) begin
            do_start(8'h40);
            check({vecs[i].name, "_ready"}, 32'(in_ready), 32'd1);
            drive(vecs[i].kind, vecs[i].rd, vecs[i].rn, vecs[i].rm, vecs[i].shamt, vecs[i].imm);
            step();
            in_valid = 1'b0;
            if (!vecs[i].exp_bad) begin
                check({vecs[i].name, "_we"}, 32'(mem_we), 32'd1);
                check({vecs[i].name, "_addr"}, 32'(mem_addr), 32'h40);
                check({vecs[i].name, "_word"}, mem_wdata, vecs[i].exp_word);
                check({vecs[i].name, "_count"}, 32'(count), 32'd1);
                check({vecs[i].name, "_err"}, 32'(err), 32'd0);
            end else begin
                check({vecs[i].name, "_we"}, 32'(mem_we), 32'd0);
                check({vecs[i].name, "_err"}, 32'(err), 32'd1);
                check({vecs[i].name, "_ready"}, 32'(in_ready), 32'd0);
                check({vecs[i].name, "_count"}, 32'(count), 32'd0);
            end
            step();
            check({vecs[i].name, "_we_pulse"}, 32'(mem_we), 32'd0);
        end

        // Recovery from error: start clears err and count, re-enables in_ready.
        do_start(8'h00);
        check("recover_err", 32'(err), 32'd0);
        check("recover_count", 32'(count), 32'd0);
        check("recover_ready", 32'(in_ready), 32'd1);

        // Back-to-back LDUR then CBZ; base low bits are ignored.
        do_start(8'h23);
        drive(KIND_LDUR, 5'd9, 5'd22, 5'd0, 6'd0, 26'd64);
        step();
        check("b2b_we0", 32'(mem_we), 32'd1);
        check("b2b_addr0", 32'(mem_addr), 32'h20);
        check("b2b_word0", mem_wdata, 32'hF84402C9);
        drive(KIND_CBZ, 5'd1, 5'd0, 5'd0, 6'd0, 26'(-2));
        step();
        in_valid = 1'b0;
        check("b2b_we1", 32'(mem_we), 32'd1);
        check("b2b_addr1", 32'(mem_addr), 32'h24);
        check("b2b_word1", mem_wdata, 32'hB4FFFFC1);
        check("b2b_count", 32'(count), 32'd2);
        drive(KIND_B, 5'd0, 5'd0, 5'd0, 6'd0, 26'd3);
        step();
        in_valid = 1'b0;
        check("b_word", mem_wdata, 32'h14000003);
        check("b_addr", 32'(mem_addr), 32'h28);

        // Full: hold 5+ ADDs valid; exactly DEPTH writes at consecutive addresses.
        do_start(8'h80);
        drive(KIND_ADD, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
        nw = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (mem_we) begin
                check("full_addr", 32'(mem_addr), 32'h80 + 32'(4 * nw));
                nw++;
            end
        end
        in_valid = 1'b0;
        check("full_writes", 32'(nw), 32'd4);
        check("full_flag", 32'(full), 32'd1);
        check("full_ready", 32'(in_ready), 32'd0);
        check("full_count", 32'(count), 32'd4);

        // Address wrap past the top of the byte space.
        do_start(8'hFC);
        drive(KIND_ADD, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
        step();
        check("wrap_addr0", 32'(mem_addr), 32'hFC);
        step();
        in_valid = 1'b0;
        check("wrap_addr1", 32'(mem_addr), 32'h00);
        check("wrap_err", 32'(err), 32'd0);

        // start with a simultaneous valid instruction: dropped.
        start     = 1'b1;
        base_addr = 8'h10;
        drive(KIND_ADD, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        check("prio_we", 32'(mem_we), 32'd0);
        check("prio_count", 32'(count), 32'd0);
        step();
        check("prio_we2", 32'(mem_we), 32'd0);

        // Reset right after a handshake cancels the write and clears outputs.
        drive(KIND_ADD, 5'd3, 5'd1, 5'd2, 6'd0, 26'd0);
        step();
        in_valid = 1'b0;
        check("mid_we", 32'(mem_we), 32'd1);
        check("mid_addr", 32'(mem_addr), 32'h10);
        rst_n = 1'b0;
        step();
        check("mid_rst_we", 32'(mem_we), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
